// File: rtl/rsa_mult_pkg.sv
// rsa_mult_pkg: shared FSM encoding and radix-select constants for rsa_mult_pipe_ctrl.
// No ports. Define RSA_MULT_RADIX4_EN to retire two multiplier bits per CALC step.
package rsa_mult_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    localparam logic [1:0] SEL_0 = 2'd0, SEL_A = 2'd1, SEL_2A = 2'd2, SEL_3A = 2'd3;
`ifdef RSA_MULT_RADIX4_EN
    localparam int BITS_PER_STEP = 2;
`else
    localparam int BITS_PER_STEP = 1;
`endif
endpackage

// File: rtl/rsa_mult_adder.sv
// rsa_mult_adder: (WIDTH+2)-bit adder folding a partial product into the upper accumulator half.
// Ports: x - upper accumulator half (WIDTH), y - partial product up to 3A (WIDTH+2),
//        sum - x + y with both carry bits kept (WIDTH+2).
module rsa_mult_adder #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH+1:0] y,
    output logic [WIDTH+1:0] sum
);
    assign sum = {2'b00, x} + y;
endmodule

// File: rtl/rsa_mult_pipe_ctrl.sv
// rsa_mult_pipe_ctrl: iterative shift-add unsigned multiplier with valid/ready handshakes.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with operands a, b (WIDTH);
//        out_valid/out_ready with product (2*WIDTH); busy high while computing.
// Define RSA_MULT_RADIX4_EN for radix-4 (WIDTH/2 steps); default is radix-2 (WIDTH steps).
module rsa_mult_pipe_ctrl
    import rsa_mult_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int N  = WIDTH / BITS_PER_STEP;
    localparam int CW = $clog2(WIDTH) + 1;
    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand, hi, lo;
    logic [WIDTH+1:0]   pp, sum;
    logic [2*WIDTH-1:0] shifted;
`ifdef RSA_MULT_RADIX4_EN
    logic [WIDTH+1:0]   mcand3;
    // 3A depends only on the latched multiplicand, so it is settled for every CALC step
    assign mcand3 = {2'b00, mcand} + {1'b0, mcand, 1'b0};
    assign pp = lo[1:0] == SEL_3A ? mcand3 :
                lo[1:0] == SEL_2A ? {1'b0, mcand, 1'b0} :
                lo[1:0] == SEL_A  ? {2'b00, mcand} : '0;
`else
    assign pp = lo[0] ? {2'b00, mcand} : '0;
`endif
    rsa_mult_adder #(.WIDTH(WIDTH)) u_adder (.x(hi), .y(pp), .sum(sum));
    // lo starts as the multiplier and fills with product bits as multiplier bits shift out
    assign shifted = (2*WIDTH)'({sum, lo} >> BITS_PER_STEP);
    assign product = {hi, lo};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mcand    <= a;
                    lo       <= b;
                    hi       <= '0;
                    cnt      <= '0;
                    state    <= CALC;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                CALC: begin
                    hi  <= shifted[2*WIDTH-1:WIDTH];
                    lo  <= shifted[WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_mult_pipe_ctrl.sv
// tb_rsa_mult_pipe_ctrl: self-checking bench for rsa_mult_pipe_ctrl at WIDTH=8 and WIDTH=128.
module tb_rsa_mult_pipe_ctrl;
`ifdef RSA_MULT_RADIX4_EN
    localparam int N8 = 4, N128 = 64;
`else
    localparam int N8 = 8, N128 = 128;
`endif
    logic         clk = 0, rst_n = 0;
    logic         in_valid = 0, out_ready = 0;
    logic [7:0]   a = 0, b = 0;
    logic         in_ready, out_valid, busy;
    logic [15:0]  product;
    logic         w_in_valid = 0, w_out_ready = 0;
    logic [127:0] w_a = 0, w_b = 0;
    logic         w_in_ready, w_out_valid, w_busy;
    logic [255:0] w_product;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    rsa_mult_pipe_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );
    rsa_mult_pipe_ctrl #(.WIDTH(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .a(w_a), .b(w_b),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .product(w_product), .busy(w_busy)
    );

    task automatic do_op8(input logic [7:0] x, input logic [7:0] y, output logic [15:0] p, output int lat);
        a = x; b = y; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        p = product;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic do_op128(input logic [127:0] x, input logic [127:0] y, output logic [255:0] p, output int lat);
        w_a = x; w_b = y; w_in_valid = 1;
        @(negedge clk);
        w_in_valid = 0;
        lat = 1;
        while (!w_out_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        p = w_product;
        w_out_ready = 1;
        @(negedge clk);
        w_out_ready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0)
            begin errors++; $display("FAIL reset_hold: out_valid=%b busy=%b product=%h, want 0 0 0000", out_valid, busy, product); end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags: out_valid=%b busy=%b want 0 0", out_valid, busy); end
        checks++;
        if (product !== 16'h0 || w_product !== 256'h0) begin errors++; $display("FAIL reset_product: got %h / %h want 0", product, w_product); end
        checks++;
        if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_busy !== 1'b0)
            begin errors++; $display("FAIL reset_wide_flags: in_ready=%b out_valid=%b busy=%b want 1 0 0", w_in_ready, w_out_valid, w_busy); end
    endtask

    task automatic test_basic;
        logic [15:0] p;
        int lat;
        do_op8(8'd13, 8'd11, p, lat);
        checks++;
        if (p !== 16'd143) begin errors++; $display("FAIL basic_product: got %0d want 143", p); end
        checks++;
        if (lat != N8 + 1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, N8 + 1); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_extremes;
        logic [15:0] p;
        logic [255:0] wp, want;
        int lat;
        do_op8(8'hFF, 8'hFF, p, lat);
        checks++;
        if (p !== 16'hFE01) begin errors++; $display("FAIL ext8_product: got %h want fe01", p); end
        want = 256'd1 - (256'd1 << 129);
        do_op128({128{1'b1}}, {128{1'b1}}, wp, lat);
        checks++;
        if (wp !== want) begin errors++; $display("FAIL ext128_product: got %h want %h", wp, want); end
        checks++;
        if (lat != N128 + 1) begin errors++; $display("FAIL ext128_latency: got %0d want %0d", lat, N128 + 1); end
    endtask

    task automatic test_zero;
        logic [15:0] p;
        int lat;
        do_op8(8'h00, 8'hA5, p, lat);
        checks++;
        if (p !== 16'h0 || lat != N8 + 1) begin errors++; $display("FAIL zero_a: product=%h lat=%0d want 0000 %0d", p, lat, N8 + 1); end
        do_op8(8'hA5, 8'h00, p, lat);
        checks++;
        if (p !== 16'h0 || lat != N8 + 1) begin errors++; $display("FAIL zero_b: product=%h lat=%0d want 0000 %0d", p, lat, N8 + 1); end
    endtask

    task automatic test_wide_random;
        logic [127:0] x, y;
        logic [255:0] wp, want;
        int lat;
        for (int i = 0; i < 4; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            y = {$urandom, $urandom, $urandom, $urandom};
            want = {128'h0, x} * {128'h0, y};
            do_op128(x, y, wp, lat);
            checks++;
            if (wp !== want) begin errors++; $display("FAIL wide_rand%0d: got %h want %h", i, wp, want); end
        end
    endtask

    task automatic test_hold;
        logic [15:0] want;
        int lat;
        a = 8'h37; b = 8'hC9; in_valid = 1;
        want = 16'h0037 * 16'h00C9;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 300) begin
            if (lat == 2) begin
                checks++;
                if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0)
                    begin errors++; $display("FAIL hold_calc_flags: busy=%b in_ready=%b out_valid=%b want 1 0 0", busy, in_ready, out_valid); end
            end
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        checks++;
        if (product !== want) begin errors++; $display("FAIL hold_product: got %h want %h", product, want); end
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom); b = 8'($urandom); in_valid = 1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || product !== want)
                begin errors++; $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b busy=%b product=%h want 1 0 0 %h", i, out_valid, in_ready, busy, product, want); end
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_reset_abort;
        logic [15:0] p;
        int lat;
        bit seen = 0;
        a = 8'hE7; b = 8'h5B; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0)
            begin errors++; $display("FAIL abort_outputs: out_valid=%b busy=%b product=%h want 0 0 0000", out_valid, busy, product); end
        @(negedge clk);
        rst_n = 1;
        repeat (N8 + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL abort_no_result: out_valid seen=1 want 0"); end
        do_op8(8'h9A, 8'h6D, p, lat);
        checks++;
        if (p !== 16'h009A * 16'h006D) begin errors++; $display("FAIL abort_next_op: got %h want %h", p, 16'h009A * 16'h006D); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] q[$];
        logic [15:0] want;
        int got = 0, last = -1, cyc = 0;
        out_ready = 1;
        in_valid = 0;
        while (got < 1000 && cyc < 1000 * (N8 + 2) + 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected: result %h with empty model queue", product);
                end else begin
                    want = q.pop_front();
                    if (product !== want) begin errors++; $display("FAIL b2b_product%0d: got %h want %h", got, product, want); end
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != N8 + 2) begin errors++; $display("FAIL b2b_period%0d: got %0d want %0d", got, cyc - last, N8 + 2); end
                end
                last = cyc;
                got++;
            end
            if (in_ready) begin
                a = 8'($urandom); b = 8'($urandom);
                q.push_back({8'h0, a} * {8'h0, b});
                in_valid = 1;
            end
        end
        in_valid = 0;
        checks++;
        if (got != 1000) begin errors++; $display("FAIL b2b_count: got %0d results want 1000", got); end
        repeat (2) @(negedge clk);
        out_ready = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_extremes();
        test_zero();
        test_wide_random();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rsa_mult_pipe_ctrl.md
RSA_MULT_PIPE_CTRL -- requirements
Module: rsa_mult_pipe_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 128, operand width in bits; must be even and at least 4.
REQ-002 SHALL have port clk, input, 1 bit, single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit, operands a/b present.
REQ-005 SHALL have port in_ready, output, 1 bit, block accepts operands.
REQ-006 SHALL have port a, input, WIDTH bits, multiplicand (unsigned).
REQ-007 SHALL have port b, input, WIDTH bits, multiplier (unsigned).
REQ-008 SHALL have port out_valid, output, 1 bit, product valid.
REQ-009 SHALL have port out_ready, input, 1 bit, consumer accepts product.
REQ-010 SHALL have port product, output, 2*WIDTH bits, a*b (unsigned, exact).
REQ-011 SHALL have port busy, output, 1 bit, high in CALC state.

Function
REQ-012 SHALL implement states IDLE, CALC, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE, busy=1 only in CALC.
REQ-013 SHALL accept operands on the edge where in_valid && in_ready; a and b are latched, the accumulator is cleared, the step counter is zeroed, and the state moves to CALC.
REQ-014 SHALL ignore a/b/in_valid outside IDLE; input changes during CALC/DONE do not affect the result.
REQ-015 SHALL, per CALC cycle in radix-2 mode, add (multiplier LSB ? multiplicand : 0) to the upper half with a carry bit, then shift the {carry, upper, lower} register right by 1.
REQ-016 SHALL spend exactly N = WIDTH CALC cycles (radix-2), so out_valid is first high N+1 cycles after the accept edge.
REQ-017 SHALL have CALC move to DONE on the edge completing step N-1; the counter has width clog2(WIDTH)+1 and never wraps.
REQ-018 SHALL hold product stable in DONE until the edge where out_valid && out_ready, then return to IDLE.
REQ-019 SHALL never combinationally depend on in_valid or out_ready for in_ready/out_valid.
REQ-020 SHALL, after the output handshake, not accept a new operand in the same cycle; in_ready rises the following cycle.
REQ-021 SHALL produce all-zero product for a=0 or b=0 with identical latency (no early termination).
REQ-022 SHALL be exact at extremes: a=b=2^WIDTH-1 gives 2^(2*WIDTH) - 2^(WIDTH+1) + 1; no carry may be lost.

Reset
REQ-023 SHALL, on rst_n low, asynchronously force state IDLE, counter 0, accumulator/product 0, in_ready 1 after release, out_valid 0, busy 0.
REQ-024 SHALL abort any operation in progress on reset assertion mid-CALC or mid-DONE; no product is delivered for it.

Configuration
REQ-025 SHALL, with RSA_MULT_RADIX4_EN defined, retire 2 multiplier bits per CALC cycle using the precomputed 0/A/2A/3A partial-product select; N = WIDTH/2.
REQ-026 SHALL, without RSA_MULT_RADIX4_EN, be radix-2 only with N = WIDTH; the product is bit-identical in both modes.

Structure
REQ-027 SHALL place the state encoding (IDLE=0, CALC=1, DONE=2) and the radix-select constants in shared package rsa_mult_pkg.
REQ-028 SHALL implement the (WIDTH+2)-bit carry-out adder as sub-module rsa_mult_adder (parameter WIDTH), reused by both modes.

Verification
REQ-029 SHALL verify: WIDTH=8, a=8'd13, b=8'd11 -> product=16'd143, out_valid high 9 cycles after accept (5 with RADIX4).
REQ-030 SHALL verify: WIDTH=8, a=b=8'hFF -> product=16'hFE01; WIDTH=128, all-ones -> the REQ-022 value.
REQ-031 SHALL verify: a=0, b=8'hA5 -> product 0 with full latency N.
REQ-032 SHALL verify: out_ready held low 20 cycles -> product/out_valid stable; in_ready stays 0; a/b toggled with in_valid=1 -> no effect.
REQ-033 SHALL verify: rst_n pulsed low at CALC step 3 -> out_valid never asserts, all outputs 0, next operation correct.
REQ-034 SHALL verify: back-to-back with in_valid and out_ready tied high -> one result per N+2 cycles, all correct over 1000 random operand pairs vs reference model.
